result_mux_pipe: RTL and testbench
==================================

RESULT_MUX_PIPE -- requirements
Module: result_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width of each channel in bits.
REQ-002 Parameter NUM_IN, default 16, number of input channels (2..256).
REQ-003 Parameter SEL_W, default 4, select/channel-index width; NUM_IN SHALL be <= 2**SEL_W.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  NUM_IN*WIDTH  flattened channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 mode  input  1  0 = direct select, 1 = round-robin arbitration.
REQ-008 sel  input  SEL_W  channel index, used in direct mode only.
REQ-009 in_valid  input  1  direct-mode request; ignored in round-robin mode.
REQ-010 req  input  NUM_IN  per-channel request vector; round-robin mode only.
REQ-011 in_ready  output  1  buffer can accept this cycle.
REQ-012 gnt  output  NUM_IN  registered one-hot grant of the last round-robin accept.
REQ-013 out_data  output  WIDTH  head-of-buffer data.
REQ-014 out_ch  output  SEL_W  channel index of head entry.
REQ-015 out_flags  output  2  {N,Z} of head entry: N = data MSB, Z = data == 0.
REQ-016 out_valid  output  1  head entry valid.
REQ-017 out_ready  input  1  consumer accepts head entry.

Function
REQ-018 Output path SHALL be a 2-entry FIFO of {data, ch, flags}; count in 0..2.
REQ-019 in_ready SHALL be combinational: 1 when count < 2, else 0.
REQ-020 Direct mode accept SHALL occur when in_valid && in_ready; entry = {in_data[sel], sel}.
REQ-021 Direct mode with sel >= NUM_IN SHALL accept data 0, out_ch = sel, flags {0,1}.
REQ-022 Round-robin accept SHALL occur when |req && in_ready; grant = first set req bit at index >= rr_ptr, searching upward with wrap to 0.
REQ-023 On a round-robin accept rr_ptr SHALL become (granted index + 1) mod NUM_IN and gnt SHALL register the one-hot grant; on no accept gnt SHALL be 0 next cycle.
REQ-024 rr_ptr SHALL hold its value while in direct mode or with req = 0.
REQ-025 Pop SHALL occur when out_valid && out_ready; head advances to the next entry.
REQ-026 Latency: an entry accepted into an empty FIFO SHALL appear on out_* on the following cycle with out_valid = 1.
REQ-027 Simultaneous accept and pop SHALL leave count unchanged with FIFO order preserved; at count = 2 no accept occurs (in_ready = 0).
REQ-028 Pop at count = 0 SHALL have no effect; out_data/out_ch/out_flags SHALL hold the last value when out_valid = 0.
REQ-029 mode SHALL be sampled every cycle; switching mode SHALL not disturb buffered entries.
REQ-030 Flags SHALL be computed at accept time and stored with the entry.

Reset
REQ-031 rst high SHALL immediately clear count, rr_ptr, gnt, out_data, out_ch, out_flags, out_valid to 0; in_ready = 1 while rst is high.
REQ-032 Reset mid-operation SHALL discard all buffered entries; no accept or pop occurs on a clock edge while rst is high.

Verification
REQ-033 Channel k = k+1, mode 0, out_ready 1, in_valid 1, sel sweep 0,1,2,3,5,8,13 -> out_data 1,2,3,4,6,9,14 each one cycle later, out_ch = sel, flags {0,0}.
REQ-034 mode 0, out_ready 0, three consecutive in_valid cycles -> in_ready drops after the 2nd accept, 3rd not accepted; raise out_ready -> two entries pop in order.
REQ-035 mode 1, req = 16'hFFFF, out_ready 1 -> gnt walks channels 0..15 then wraps to 0; out_data 1..16, 1.
REQ-036 mode 1, rr_ptr = 14, req = 16'h0005 -> grant channel 0, then channel 2, then channel 0.
REQ-037 Channel 3 = 32'h8000_0000, channel 4 = 0, direct-select 3 then 4 -> out_flags {1,0} then {0,1}.
REQ-038 FIFO holding 2 entries, assert rst asynchronously between edges -> out_valid 0 and in_ready 1 immediately, no stale entry after release.

Source files
------------

// File: rtl/result_mux_pipe_if.sv
// Channel-select / round-robin request bus and the 2-deep result stream it feeds.
interface result_mux_pipe_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 16,
    parameter int unsigned SEL_W  = 4
) ();
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic [NUM_IN-1:0]       req;
    logic                    in_ready;
    logic [NUM_IN-1:0]       gnt;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic [1:0]              out_flags;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, mode, sel, in_valid, req, out_ready,
        input  in_ready, gnt, out_data, out_ch, out_flags, out_valid
    );

    modport slave (
        input  in_data, mode, sel, in_valid, req, out_ready,
        output in_ready, gnt, out_data, out_ch, out_flags, out_valid
    );
endinterface

// File: rtl/result_mux_pipe.sv
// Selects one input channel (direct index or round-robin) and buffers
// {data, channel, flags} in a 2-entry output FIFO whose head drives out_*.
module result_mux_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 16,
    parameter int unsigned SEL_W  = 4
) (
    input logic clk,
    input logic rst,
    result_mux_pipe_if.slave bus
);
    logic [1:0]        count;
    logic [SEL_W-1:0]  rr_ptr;
    logic [WIDTH-1:0]  tail_data;
    logic [SEL_W-1:0]  tail_ch;
    logic [1:0]        tail_flags;

    logic              hi_found, lo_found;
    logic [SEL_W-1:0]  hi_idx, lo_idx, rr_idx, acc_idx, rr_ptr_nxt;
    logic [WIDTH-1:0]  acc_data;
    logic [1:0]        acc_flags;
    logic [NUM_IN-1:0] gnt_nxt;
    logic              accept, rr_acc, pop;

    assign bus.in_ready = (count < 2'd2);

    // Lowest requesting channel at/above rr_ptr, falling back to lowest overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                if (SEL_W'(k) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(k);
                end
                lo_found = 1'b1;
                lo_idx   = SEL_W'(k);
            end
        end
        rr_idx = hi_found ? hi_idx : lo_idx;
    end

    assign acc_idx    = bus.mode ? rr_idx : bus.sel;
    assign accept     = bus.in_ready && (bus.mode ? lo_found : bus.in_valid);
    assign rr_acc     = accept && bus.mode;
    assign pop        = bus.out_valid && bus.out_ready;
    assign rr_ptr_nxt = (rr_idx == SEL_W'(NUM_IN - 1)) ? '0 : rr_idx + SEL_W'(1);

    // Shared channel mux; indices past NUM_IN read as zero.
    always_comb begin
        acc_data = '0;
        gnt_nxt  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (acc_idx == SEL_W'(k)) begin
                acc_data   = bus.in_data[k*WIDTH +: WIDTH];
                gnt_nxt[k] = 1'b1;
            end
        end
        acc_flags = {acc_data[WIDTH-1], acc_data == '0};
    end

    // Head register is the visible output; tail only holds the second entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            rr_ptr        <= '0;
            bus.gnt       <= '0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.out_flags <= '0;
            bus.out_valid <= 1'b0;
            tail_data     <= '0;
            tail_ch       <= '0;
            tail_flags    <= '0;
        end else begin
            bus.gnt <= rr_acc ? gnt_nxt : '0;
            if (rr_acc) rr_ptr <= rr_ptr_nxt;
            case (count)
                2'd0: begin
                    if (accept) begin
                        bus.out_data  <= acc_data;
                        bus.out_ch    <= acc_idx;
                        bus.out_flags <= acc_flags;
                        bus.out_valid <= 1'b1;
                        count         <= 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && pop) begin
                        bus.out_data  <= acc_data;
                        bus.out_ch    <= acc_idx;
                        bus.out_flags <= acc_flags;
                    end else if (accept) begin
                        tail_data  <= acc_data;
                        tail_ch    <= acc_idx;
                        tail_flags <= acc_flags;
                        count      <= 2'd2;
                    end else if (pop) begin
                        bus.out_valid <= 1'b0;
                        count         <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        bus.out_data  <= tail_data;
                        bus.out_ch    <= tail_ch;
                        bus.out_flags <= tail_flags;
                        count         <= 2'd1;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    count         <= 2'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_mux_pipe.sv
// Randomized scoreboard bench for result_mux_pipe: predictor pushes expected
// entries at accept time, monitor pops and compares when the DUT pops.
module tb_result_mux_pipe;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 16;
    localparam int unsigned SEL_W  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] ch;
        logic [1:0]       flags;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    result_mux_pipe_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

    result_mux_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    ent_t exp_q[$];
    int   rr_ptr   = 0;
    logic [NUM_IN-1:0] exp_gnt = '0;
    int   pre_size = 0;
    ent_t last_head = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Predictor: decides from the model's own occupancy whether this edge accepts.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rr_ptr   = 0;
            exp_gnt  = '0;
            pre_size = 0;
        end else begin
            int   ch;
            bit   acc;
            ent_t e;
            chk("gnt", 64'(bus.gnt), 64'(exp_gnt));
            chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
            pre_size = exp_q.size();
            acc = 1'b0;
            ch  = 0;
            if (exp_q.size() < 2) begin
                if (!bus.mode && bus.in_valid) begin
                    acc = 1'b1;
                    ch  = int'(bus.sel);
                end else if (bus.mode && bus.req != '0) begin
                    for (int i = 0; i < int'(NUM_IN); i++) begin
                        int idx;
                        idx = (rr_ptr + i) % int'(NUM_IN);
                        if (!acc && bus.req[idx]) begin
                            acc = 1'b1;
                            ch  = idx;
                        end
                    end
                    rr_ptr = (ch + 1) % int'(NUM_IN);
                end
            end
            exp_gnt = '0;
            if (acc && bus.mode) exp_gnt[ch] = 1'b1;
            if (acc) begin
                e.data  = (ch < int'(NUM_IN)) ? bus.in_data[ch*WIDTH +: WIDTH] : '0;
                e.ch    = SEL_W'(ch);
                e.flags = {e.data[WIDTH-1], e.data == '0};
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: checks the head whenever it is presented, and the hold value when not.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            last_head = '0;
        end else begin
            chk("out_valid", 64'(bus.out_valid), 64'(pre_size != 0));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(1), 64'(0));
                end else begin
                    chk("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
                    chk("out_ch", 64'(bus.out_ch), 64'(exp_q[0].ch));
                    chk("out_flags", 64'(bus.out_flags), 64'(exp_q[0].flags));
                    if (bus.out_ready) last_head = exp_q.pop_front();
                end
            end else begin
                chk("hold_data", 64'(bus.out_data), 64'(last_head.data));
                chk("hold_ch", 64'(bus.out_ch), 64'(last_head.ch));
                chk("hold_flags", 64'(bus.out_flags), 64'(last_head.flags));
            end
        end
    end

    task automatic set_ramp();
        for (int k = 0; k < int'(NUM_IN); k++) bus.in_data[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.req      = '0;
    endtask

    initial begin
        int sweep [7] = '{0, 1, 2, 3, 5, 8, 13};
        bus.in_data = '0; bus.mode = 1'b0; bus.sel = '0; bus.in_valid = 1'b0;
        bus.req = '0; bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_gnt", 64'(bus.gnt), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        repeat (2) step();
        rst = 1'b0;

        // Direct sweep over the ramp pattern.
        set_ramp();
        bus.in_valid = 1'b1;
        foreach (sweep[i]) begin
            bus.sel = SEL_W'(sweep[i]);
            step();
        end
        idle(); repeat (3) step();

        // Sign and zero flags.
        bus.in_data[3*WIDTH +: WIDTH] = 32'h8000_0000;
        bus.in_data[4*WIDTH +: WIDTH] = 32'h0;
        bus.in_valid = 1'b1;
        bus.sel = 4'd3; step();
        bus.sel = 4'd4; step();
        idle(); repeat (3) step();
        set_ramp();

        // Backpressure: third request must be refused.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.sel = SEL_W'(i + 6);
            step();
        end
        idle(); step();
        bus.out_ready = 1'b1; repeat (3) step();

        // Round-robin walk with every channel requesting, through the wrap.
        bus.mode = 1'b1;
        bus.req = 16'hFFFF; repeat (17) step();
        idle(); step();

        // Park the pointer at 14, then a sparse request wraps to 0, 2, 0.
        bus.req = 16'h2000; step();
        bus.req = 16'h0005; repeat (3) step();
        idle(); repeat (3) step();

        // Asynchronous reset with a full FIFO.
        bus.mode = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.sel = 4'd9; step();
        bus.sel = 4'd10; step();
        idle(); step();
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("arst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("arst_out_data", 64'(bus.out_data), 64'(0));
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1; repeat (3) step();

        // Randomized traffic with one reset mid-run.
        for (int n = 0; n < 400; n++) begin
            bus.mode      = 1'($urandom_range(0, 1));
            bus.sel       = SEL_W'($urandom_range(0, NUM_IN - 1));
            bus.in_valid  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       bus.req = '0;
                1:       bus.req = NUM_IN'(1) << $urandom_range(0, NUM_IN - 1);
                default: bus.req = NUM_IN'($urandom);
            endcase
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < int'(NUM_IN); k++) begin
                case ($urandom_range(0, 7))
                    0:       bus.in_data[k*WIDTH +: WIDTH] = '0;
                    1:       bus.in_data[k*WIDTH +: WIDTH] = 32'h8000_0000;
                    default: bus.in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
                endcase
            end
            if (n == 200) begin
                #2 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
            end
            step();
        end

        idle(); bus.mode = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
        repeat (2) step();
        chk("drain", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
